// File: rtl/frame_read_scan_if.sv
// Framebuffer read port and pixel-beat stream of the frame read scanner.
`timescale 1ns/1ps
interface frame_read_scan_if;
    logic [14:0] rd_addr;
    logic        rd_en;
    logic [2:0]  rd_data;
    logic [7:0]  out_x;
    logic [6:0]  out_y;
    logic [2:0]  out_colour;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output rd_addr, rd_en,
        input  rd_data,
        output out_x, out_y, out_colour, out_valid,
        input  out_ready
    );

    modport slave (
        input  rd_addr, rd_en,
        output rd_data,
        input  out_x, out_y, out_colour, out_valid,
        output out_ready
    );
endinterface

// File: rtl/frame_read_scan.sv
// Raster-order framebuffer reader: streams (x, y, colour) beats and counts
// non-background pixels of the sweep.
`timescale 1ns/1ps
module frame_read_scan #(
    parameter int         WIDTH     = 160,
    parameter int         HEIGHT    = 120,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [14:0]       match_count,
    frame_read_scan_if.master bus
);
    localparam logic [7:0]  X_LAST = 8'(WIDTH - 1);
    localparam logic [6:0]  Y_LAST = 7'(HEIGHT - 1);
    localparam logic [14:0] PIXELS = 15'(WIDTH * HEIGHT);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } beat_t;

    state_t      state, state_nxt;
    logic [7:0]  x_cnt;
    logic [6:0]  y_cnt;
    logic [14:0] addr_cnt;
    logic [7:0]  x_p1;
    logic [6:0]  y_p1;
    logic        vld_p1;
    beat_t       fifo [2];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  entries;
    logic [1:0]  occ_after;
    beat_t       fresh, head;
    logic        from_fifo, pop, issue, last_issue;

    // The returning read bypasses the empty buffer so a beat is offered the
    // same cycle the RAM data arrives.
    always_comb begin
        fresh     = '{x: x_p1, y: y_p1, c: bus.rd_data};
        from_fifo = (entries != 2'd0);
        head      = from_fifo ? fifo[rd_ptr] : fresh;
        pop       = (from_fifo | vld_p1) & bus.out_ready;
        occ_after = entries + 2'(vld_p1) - 2'(pop);
        issue     = (state == SCAN) && (occ_after < 2'd2);
        last_issue = issue && (x_cnt == X_LAST) && (y_cnt == Y_LAST);
    end

    assign bus.rd_en      = issue;
    assign bus.rd_addr    = addr_cnt;
    assign bus.out_valid  = from_fifo | vld_p1;
    assign bus.out_x      = bus.out_valid ? head.x : '0;
    assign bus.out_y      = bus.out_valid ? head.y : '0;
    assign bus.out_colour = bus.out_valid ? head.c : '0;
    assign busy           = (state != IDLE);
    assign done           = (state == FIN);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = SCAN;
            SCAN:  if (last_issue) state_nxt = DRAIN;
            DRAIN: if (occ_after == 2'd0) state_nxt = FIN;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Issue stage: running address alongside x/y, no multiplier.
    always_ff @(posedge clk) begin
        if (!reset_n || (state == IDLE && start)) begin
            x_cnt    <= '0;
            y_cnt    <= '0;
            addr_cnt <= '0;
        end else if (issue) begin
            addr_cnt <= addr_cnt + 15'd1;
            if (x_cnt == X_LAST) begin
                x_cnt <= '0;
                y_cnt <= y_cnt + 7'd1;
            end else begin
                x_cnt <= x_cnt + 8'd1;
            end
        end
    end

    // Stage p1: coordinates travel with the read and pair with rd_data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
            x_p1   <= '0;
            y_p1   <= '0;
        end else begin
            vld_p1 <= issue;
            if (issue) begin
                x_p1 <= x_cnt;
                y_p1 <= y_cnt;
            end
        end
    end

    // Output buffer: returning beat is stored unless it leaves via bypass.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            entries <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            fifo[0] <= '0;
            fifo[1] <= '0;
        end else begin
            entries <= occ_after;
            if (vld_p1 && !(pop && !from_fifo)) begin
                fifo[wr_ptr] <= fresh;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop && from_fifo) rd_ptr <= ~rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || (state == IDLE && start)) begin
            match_count <= '0;
        end else if (pop && head.c != BG_COLOUR && match_count != PIXELS) begin
            match_count <= match_count + 15'd1;
        end
    end
endmodule

// File: tb/tb_frame_read_scan.sv
// Scoreboard bench for frame_read_scan: driver queues expected beats, a
// negedge monitor checks beats, addresses, stalls, credit and done timing.
`timescale 1ns/1ps
module tb_frame_read_scan;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        busy, done;
    logic [14:0] match_count;

    frame_read_scan_if bus();

    frame_read_scan dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .match_count (match_count),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    logic [2:0]  mem [19200];
    logic [17:0] q [$];
    int vectors = 0, miscompares = 0;
    int nsince = 0, done_cnt = 0, d0 = 0;
    int issued = 0, beats_acc = 0, exp_addr = 0;
    bit chk_lat = 0, rnd_mode = 0, prev_stall = 0;
    logic [17:0] held = '0;
    logic [17:0] cur;

    always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

    initial begin
        bus.rd_data   = '0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 bus.out_ready = rnd_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    assign cur = {bus.out_x, bus.out_y, bus.out_colour};

    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
            prev_stall = 0;
            issued     = 0;
            beats_acc  = 0;
            exp_addr   = 0;
        end else begin
            nsince++;
            if (chk_lat && nsince == 1) begin
                chk("first_rd_en", 32'(bus.rd_en), 1);
                chk("no_early_valid", 32'(bus.out_valid), 0);
            end
            if (chk_lat && nsince == 2) chk("first_valid", 32'(bus.out_valid), 1);
            if (prev_stall) begin
                chk("stall_valid", 32'(bus.out_valid), 1);
                chk("stall_beat", 32'(cur), 32'(held));
            end
            chk("credit", 32'((issued - beats_acc) <= 2), 1);
            if (bus.rd_en) begin
                chk("rd_addr", 32'(bus.rd_addr), 32'(exp_addr));
                exp_addr++;
                issued++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_beat: got 0x%0h expected none", cur);
                end else begin
                    chk("beat", 32'(cur), 32'(q.pop_front()));
                end
                beats_acc++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            held       = cur;
            if (done) begin
                done_cnt++;
                if (chk_lat) chk("done_latency", nsince, 19202);
            end
        end
    end

    task automatic load_mem(input bit pat);
        for (int i = 0; i < 19200; i++) mem[i] = pat ? 3'(i) : 3'd0;
    endtask

    task automatic push_sweep(input bit pat);
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                q.push_back({8'(x), 7'(y), pat ? 3'(y * 160 + x) : 3'd0});
    endtask

    task automatic run_start(input bit lat);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        nsince    = 0;
        exp_addr  = 0;
        issued    = 0;
        beats_acc = 0;
        chk_lat   = lat;
        d0        = done_cnt;
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int i;
        for (i = 0; i < limit && done_cnt == d0; i++) @(posedge clk);
        if (done_cnt == d0) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", limit);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_rd_en"}, 32'(bus.rd_en), 0);
        chk({tag, "_rd_addr"}, 32'(bus.rd_addr), 0);
        chk({tag, "_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_x"}, 32'(bus.out_x), 0);
        chk({tag, "_y"}, 32'(bus.out_y), 0);
        chk({tag, "_colour"}, 32'(bus.out_colour), 0);
        chk({tag, "_match"}, 32'(match_count), 0);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        load_mem(1'b1);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_zero("reset");

        // Pattern sweep, ready high, a second start mid-sweep must be ignored.
        push_sweep(1'b1);
        run_start(1'b1);
        while (nsince < 500) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(25000);
        repeat (10) @(posedge clk);
        chk("done_pulses", done_cnt - d0, 1);
        chk("leftover_beats", q.size(), 0);
        chk("match_pattern", 32'(match_count), 16800);
        chk("busy_after_done", 32'(busy), 0);

        // Random stalls, then a one-cycle reset at beat 7000.
        rnd_mode = 1'b1;
        push_sweep(1'b1);
        run_start(1'b0);
        for (int i = 0; i < 40000 && beats_acc < 7000; i++) @(posedge clk);
        chk("beats_before_abort", 32'(beats_acc >= 7000), 1);
        chk("busy_mid_sweep", 32'(busy), 1);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_zero("abort");
        rnd_mode = 1'b0;
        repeat (30) @(posedge clk);
        chk("no_done_after_abort", done_cnt - d0, 0);

        // Fresh sweep over an all-black frame.
        load_mem(1'b0);
        push_sweep(1'b0);
        run_start(1'b1);
        wait_done(25000);
        repeat (10) @(posedge clk);
        chk("done_pulses_black", done_cnt - d0, 1);
        chk("leftover_black", q.size(), 0);
        chk("match_black", 32'(match_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/frame_read_scan.md
Name: frame_read_scan

Overview:
- Reader counterpart to the screen-clear writer. The writer sweeps 160x120 coordinates into the framebuffer; this block sweeps the same coordinates back out of it.
- On a start pulse it reads every framebuffer pixel through a synchronous-read RAM port, in raster order.
- It streams (x, y, colour) beats to a consumer under a valid/ready handshake, and counts pixels that differ from the background colour.
- Used for collision readback, screen verification, and frame dump in the snake game.

Parameters:
- WIDTH, 160, pixels per row; x counts 0..WIDTH-1.
- HEIGHT, 120, rows; y counts 0..HEIGHT-1.
- BG_COLOUR, 3'b000, background colour excluded from match_count.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin a sweep; ignored while busy.
- busy  out  1  high from the cycle after start is accepted until done pulses.
- done  out  1  one-cycle pulse after the final beat is accepted.
- rd_addr  out  15  framebuffer read address, equal to y*WIDTH + x.
- rd_en  out  1  read strobe; RAM data is valid exactly 1 cycle later.
- rd_data  in  3  colour returned by the RAM.
- out_x  out  8  pixel x of the current beat.
- out_y  out  7  pixel y of the current beat.
- out_colour  out  3  pixel colour of the current beat.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts the beat when valid and ready are both high.
- match_count  out  15  number of accepted beats with colour != BG_COLOUR in the current or last sweep.

Behaviour:
- Synchronous reset (reset_n low at posedge):
  - FSM goes to IDLE.
  - busy=0, done=0, rd_en=0, rd_addr=0, out_valid=0, out_x=0, out_y=0, out_colour=0, match_count=0.
  - Issue counters, in-flight flag and buffer are cleared.
  - Reset mid-sweep aborts the sweep; no done pulse follows.
- FSM states: IDLE, SCAN, DRAIN, FIN.
  - IDLE -> SCAN when start=1. Issue counters are set to (0,0); match_count is cleared; busy goes to 1 next cycle.
  - SCAN issues reads. Move to DRAIN in the cycle the read for (WIDTH-1, HEIGHT-1) is issued.
  - DRAIN waits until the in-flight read has returned and the buffer is empty, then moves to FIN.
  - FIN pulses done=1 for one cycle, drops busy, returns to IDLE.
  - start in any state other than IDLE is ignored.
- Address generation:
  - Use a running address counter alongside x/y; no multiplier.
  - x increments per issued read. At x=WIDTH-1, x wraps to 0 and y increments.
  - The address increments by 1 per issue, so the final address is 19199.
- Read pipeline:
  - rd_en=1 for exactly one cycle per issued pixel.
  - The issued x/y travel alongside the read, 1-cycle delayed, and pair with rd_data.
- Output buffer: 2-entry FIFO of {x, y, colour}.
  - Issue is allowed in a cycle iff (entries + inflight - pop) < 2, where pop = out_valid & out_ready.
  - This guarantees no overflow.
  - out_valid = buffer non-empty; the head drives out_x, out_y and out_colour.
  - Beats are never dropped or duplicated.
  - Output signals are stable while out_valid=1 and out_ready=0.
- Throughput and latency:
  - With out_ready held high: start accepted at edge N, first rd_en during cycle N+1, first out_valid during cycle N+2.
  - After that, one beat per cycle.
  - The last beat is accepted during cycle N+19201; done is high during cycle N+19202.
- match_count:
  - Increments on each accepted beat whose colour != BG_COLOUR.
  - Saturates at 19200, which equals the number of pixels.
  - Holds its value after done until the next start.
- Simultaneous events:
  - A start in the same cycle as done is ignored, because the FSM is not in IDLE.
  - Push and pop in the same cycle leave the buffer occupancy unchanged.

Test Plan:
- Reset, then start with out_ready=1 and RAM preloaded with colour = addr[2:0]:
  - Expect 19200 beats in raster order, (0,0) through (159,119), each colour = (y*160+x)[2:0].
  - Expect done exactly 19202 cycles after start and match_count=16800.
- All-black RAM:
  - Expect match_count=0, and out_colour=0 on every beat.
- Random out_ready (about 30% duty):
  - Expect the same beat sequence as with out_ready=1, with no loss or duplication.
  - Expect out_x, out_y and out_colour held stable while stalled.
  - Expect the RAM never to have more than 1 read in flight beyond the buffer credit.
- Row wrap:
  - Expect the beat after (159,0) to be (0,1).
  - Expect the rd_addr sequence to be contiguous (159, 160, ...).
- Start pulsed again at cycle 500 of a sweep:
  - Expect it to be ignored, the sweep to complete unchanged, and exactly one done pulse.
- reset_n low for 1 cycle at beat 7000, then start:
  - Expect all outputs to be 0 the cycle after reset.
  - Expect a fresh sweep from (0,0), with match_count restarting at 0.
